// File: rtl/overdrive_ctrl.sv
// ---------------------------------------------------------------------------
// overdrive_ctrl
//   Sequencer in front of the overdrive datapath. Each accepted sample is
//   registered into the overdrive input together with the applied gain. The
//   gain slews one STEP per accepted sample toward an effective target, so
//   gain target changes never produce zipper noise. A bypass FSM fades the
//   gain back to unity before it switches the output to the dry signal. The
//   overdrive result is captured into a registered, valid-qualified output
//   stream.
//
// Ports
//   clk              in   1       system clock
//   rst_n            in   1       synchronous reset, active low
//   sample_valid     in   1       strobe: sample_in accepted this cycle
//   sample_in        in   16      signed PCM sample
//   gain_target      in   GAIN_W  requested drive gain (control)
//   bypass_req       in   1       level: 1 = bypass the effect
//   od_signal_in     out  16      registered sample to the overdrive
//   od_gain          out  GAIN_W  registered applied gain to the overdrive
//   od_signal_out    in   32      overdrive result (combinational, signed)
//   sample_out       out  32      processed or dry sample
//   sample_out_valid out  1       strobe qualifying sample_out
//   ramping          out  1       applied gain differs from effective target
//   bypassed         out  1       FSM is in BYPASS
// ---------------------------------------------------------------------------
module overdrive_ctrl #(
   parameter int GAIN_W    = 16,
   parameter int GAIN_FRAC = 4,
   parameter int STEP      = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [15:0]       sample_in,
   input  logic [GAIN_W-1:0] gain_target,
   input  logic              bypass_req,
   output logic [15:0]       od_signal_in,
   output logic [GAIN_W-1:0] od_gain,
   input  logic [31:0]       od_signal_out,
   output logic [31:0]       sample_out,
   output logic              sample_out_valid,
   output logic              ramping,
   output logic              bypassed
);

   localparam logic [GAIN_W-1:0] UNITY  = {{(GAIN_W-1){1'b0}}, 1'b1} << GAIN_FRAC;
   localparam logic [GAIN_W:0]   STEP_X = (GAIN_W+1)'(STEP);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FADE   = 2'd1,
      ST_BYPASS = 2'd2
   } state_t;

   state_t            state;
   logic [GAIN_W-1:0] target;
   logic [GAIN_W-1:0] gain_next;
   logic [GAIN_W:0]   gain_up;
   logic [GAIN_W:0]   gain_dn;
   logic              s1_valid;
   logic              s1_byp;

   // Effective gain target: the requested gain only while ACTIVE, unity otherwise.
   always_comb begin
      case (state)
         ST_ACTIVE: target = gain_target;
         ST_FADE:   target = UNITY;
         ST_BYPASS: target = UNITY;
         default:   target = UNITY;
      endcase
   end

   // One-step slew toward the target, one bit wider so it clamps instead of wrapping.
   always_comb begin
      gain_up = {1'b0, od_gain} + STEP_X;
      gain_dn = {1'b0, od_gain} - STEP_X;
      if (od_gain < target) begin
         if (gain_up >= {1'b0, target}) begin
            gain_next = target;
         end else begin
            gain_next = gain_up[GAIN_W-1:0];
         end
      end else if (od_gain > target) begin
         // MSB set means the subtraction went below zero
         if (gain_dn[GAIN_W] || (gain_dn <= {1'b0, target})) begin
            gain_next = target;
         end else begin
            gain_next = gain_dn[GAIN_W-1:0];
         end
      end else begin
         gain_next = od_gain;
      end
   end

   // Bypass FSM, gain/sample input stage and output capture stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_ACTIVE;
         od_gain          <= UNITY;
         od_signal_in     <= 16'h0000;
         s1_valid         <= 1'b0;
         s1_byp           <= 1'b0;
         sample_out       <= 32'h0000_0000;
         sample_out_valid <= 1'b0;
      end else begin
         if (sample_valid) begin
            od_signal_in <= sample_in;
            od_gain      <= gain_next;
            // the sample that enters BYPASS is still processed; dry starts next accept
            s1_byp       <= (state == ST_BYPASS);
            case (state)
               ST_ACTIVE: begin
                  if (bypass_req) state <= ST_FADE;
                  else            state <= ST_ACTIVE;
               end
               ST_FADE: begin
                  if (!bypass_req)              state <= ST_ACTIVE;
                  else if (gain_next == UNITY)  state <= ST_BYPASS;
                  else                          state <= ST_FADE;
               end
               ST_BYPASS: begin
                  if (!bypass_req) state <= ST_ACTIVE;
                  else             state <= ST_BYPASS;
               end
               default: state <= ST_ACTIVE;
            endcase
         end else begin
            od_signal_in <= od_signal_in;
            od_gain      <= od_gain;
            s1_byp       <= s1_byp;
            state        <= state;
         end

         s1_valid         <= sample_valid;
         sample_out_valid <= s1_valid;
         if (s1_valid) begin
            sample_out <= s1_byp ? {{16{od_signal_in[15]}}, od_signal_in} : od_signal_out;
         end else begin
            sample_out <= sample_out;
         end
      end
   end

   assign ramping  = (state != ST_BYPASS) && (od_gain != target);
   assign bypassed = (state == ST_BYPASS);

endmodule
